// File: rtl/mem_responder.sv
// Single-port word memory behind a 4-phase req/ack handshake with a programmable wait.
// Response registered on entry to RESP; ack held until req drops.
module mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [DEPTH];

  // With no wait states the commit happens on the capture edge, so use live inputs there.
  logic                  use_in;
  logic [31:0]           c_addr;
  logic [31:0]           c_wdata;
  logic [3:0]            c_be;
  logic                  c_we;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  c_err;
  logic                  enter_resp;
  logic [31:0]           merged_d;

  assign use_in     = (state_q == IDLE);
  assign c_addr     = use_in ? addr  : addr_q;
  assign c_wdata    = use_in ? wdata : wdata_q;
  assign c_be       = use_in ? be    : be_q;
  assign c_we       = use_in ? we    : we_q;
  assign c_idx      = c_addr[DEPTH_LOG2+1:2];
  assign c_err      = (c_addr[1:0] != 2'b00) || ((c_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign enter_resp = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));

  always_comb begin
    merged_d = mem_q[c_idx];
    for (int i = 0; i < 4; i++) begin
      if (c_be[i]) merged_d[8*i +: 8] = c_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          if (!req) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (enter_resp) begin
        ack_q <= 1'b1;
        if (c_err) begin
          err_q   <= 1'b1;
          rdata_q <= 32'd0;
        end else if (c_we) begin
          err_q          <= 1'b0;
          mem_q[c_idx]   <= merged_d;
          rdata_q        <= 32'd0;
        end else begin
          err_q   <= 1'b0;
          rdata_q <= mem_q[c_idx];
        end
      end
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none; shared data inputs.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_v;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [1:0]  ack_v;
  logic [1:0]  err_v;
  logic [1:0]  busy_v;
  logic [31:0] rdata_v [2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] r_obs;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(rst_n), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .busy(busy_v[0])
  );

  mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst_n), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .busy(busy_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input int key);
    return model.exists(key) ? model[key] : 32'd0;
  endfunction

  task automatic scramble();
    we    = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    be    = 4'($urandom);
  endtask

  // Drive one transaction on instance sel; hold = cycles req stays high after ack,
  // early = drop req right after it has been sampled.
  task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input int hold, input bit early,
                     output logic [31:0] robs);
    int   wc;
    int   cycles;
    int   key;
    bit   e;
    exp_t x;
    logic [31:0] nw;
    wc  = (sel == 0) ? 2 : 0;
    e   = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    key = sel * 4096 + int'(a[11:2]);
    x.err = e;
    x.rdata = 32'd0;
    if (!e && w) begin
      nw = mrd(key);
      for (int i = 0; i < 4; i++) if (b[i]) nw[8*i +: 8] = d[8*i +: 8];
      model[key] = nw;
    end else if (!e) begin
      x.rdata = mrd(key);
    end
    sb.push_back(x);

    @(negedge clk);
    we = w; addr = a; wdata = d; be = b;
    req_v[sel] = 1'b1;
    cycles = 0;
    while (cycles < 20) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (early) req_v[sel] = 1'b0;
      if (ack_v[sel]) break;
      scramble();
    end
    chk("ack_seen", 32'(ack_v[sel]), 32'd1);
    chk("latency", cycles, wc + 1);
    chk("busy_in_resp", 32'(busy_v[sel]), 32'd1);
    x = sb.pop_front();
    robs = rdata_v[sel];
    chk("rdata", rdata_v[sel], x.rdata);
    chk("err", 32'(err_v[sel]), 32'(x.err));
    scramble();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      scramble();
      chk("ack_held", 32'(ack_v[sel]), 32'd1);
      chk("rdata_held", rdata_v[sel], x.rdata);
    end
    req_v[sel] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ack_drop", 32'(ack_v[sel]), 32'd0);
    chk("busy_drop", 32'(busy_v[sel]), 32'd0);
    chk("rdata_clr", rdata_v[sel], 32'd0);
    chk("err_clr", 32'(err_v[sel]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_v = 2'b00;
    we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ack", 32'(ack_v[s]), 32'd0);
      chk("rst_busy", 32'(busy_v[s]), 32'd0);
      chk("rst_rdata", rdata_v[s], 32'd0);
      chk("rst_err", 32'(err_v[s]), 32'd0);
    end
    rst_n = 1'b1;

    // write then read back
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, r_obs);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, r_obs);
    chk("wr_rd", r_obs, 32'hDEADBEEF);

    // byte enables
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'hF, 0, 1'b0, r_obs);
    txn(0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, 1'b0, r_obs);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, r_obs);
    chk("be_merge", r_obs, 32'h11BB33DD);

    // errors: misaligned read, out-of-range write aliasing word 0
    txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, 1'b0, r_obs);
    txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 1'b0, r_obs);
    txn(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 0, 1'b0, r_obs);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, r_obs);
    chk("err_wr_nochange", r_obs, 32'hCAFEF00D);

    // be=0 write leaves memory alone
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 1'b0, r_obs);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, r_obs);
    chk("be0_nochange", r_obs, 32'h11BB33DD);

    // req held 5 cycles past ack, then early drop during WAIT
    txn(0, 1'b1, 32'h30, 32'h12345678, 4'hF, 5, 1'b0, r_obs);
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b1, r_obs);
    chk("hold_wr_rd", r_obs, 32'h12345678);

    // reset during WAIT of a write to 0x20
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5; be = 4'hF;
    req_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack_v[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
    chk("mid_rst_rdata", rdata_v[0], 32'd0);
    req_v[0] = 1'b0;
    model.delete();
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, r_obs);
    chk("rst_abort_wr", r_obs, 32'd0);
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, r_obs);
    chk("rst_clears_mem", r_obs, 32'd0);

    // zero-wait instance, back-to-back
    txn(1, 1'b1, 32'h40, 32'h0BADC0DE, 4'hF, 0, 1'b0, r_obs);
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, r_obs);
    chk("w0_wr_rd", r_obs, 32'h0BADC0DE);
    txn(1, 1'b1, 32'h44, 32'h01020304, 4'b1010, 0, 1'b0, r_obs);
    txn(1, 1'b0, 32'h44, 32'h0, 4'h0, 0, 1'b0, r_obs);
    chk("w0_be", r_obs, 32'h01000300);
    txn(1, 1'b0, 32'h3, 32'h0, 4'h0, 0, 1'b0, r_obs);
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 2, 1'b0, r_obs);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
